// File: rtl/plru_pkg.sv
// ----------------------------------------------------------------------------
// plru_pkg
//
// Shared types for the tree pseudo-LRU set controller.
//
//   op_e         : request opcode carried on req_op
//                  (TOUCH / VICTIM / ALLOC / CLEAR_SET)
//   fsm_state_e  : controller state, either serving requests (S_IDLE)
//                  or sweeping every set back to an all-zero tree (S_FLUSH)
// ----------------------------------------------------------------------------
package plru_pkg;

    typedef enum logic [1:0] {
        OP_TOUCH     = 2'b00,
        OP_VICTIM    = 2'b01,
        OP_ALLOC     = 2'b10,
        OP_CLEAR_SET = 2'b11
    } op_e;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } fsm_state_e;

endpackage

// File: rtl/plru_tree_logic.sv
// ----------------------------------------------------------------------------
// plru_tree_logic
//
// Purely combinational helper for one (ASSOC-1)-bit PLRU tree. The tree is
// stored heap-style: node 0 is the root, and the children of node n are
// 2n+1 (left) and 2n+2 (right). A node bit of 0 points the victim into the
// left subtree, and a bit of 1 points it into the right subtree.
//
// Ports:
//   tree       in  ASSOC-1  current tree bits of the addressed set
//   touch_way  in  WAY_W    way to mark most-recently-used
//   victim     out WAY_W    way the tree currently points at (root = MSB)
//   new_tree   out ASSOC-1  tree after touching touch_way
// ----------------------------------------------------------------------------
module plru_tree_logic #(
    parameter int ASSOC = 8,
    localparam int WAY_W = $clog2(ASSOC)
) (
    input  logic [ASSOC-2:0] tree,
    input  logic [WAY_W-1:0] touch_way,
    output logic [WAY_W-1:0] victim,
    output logic [ASSOC-2:0] new_tree
);

    // Walk from the root, following the node bits. Each bit on the walk
    // becomes the next way bit, root first. The victim walk and the update
    // walk are kept in separate blocks so that the caller can feed the
    // victim back in as the touch way (ALLOC) without forming a loop.
    always_comb begin : victim_walk
        int node;
        victim = '0;
        node   = 0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            victim[WAY_W-1-lvl] = tree[node];
            node = tree[node] ? (2 * node + 2) : (2 * node + 1);
        end
    end

    // Follow touch_way's own path. Every node on the path is flipped to
    // point away from the touched way. Nodes off the path keep their
    // value because new_tree starts as a copy of tree.
    always_comb begin : touch_walk
        int node;
        new_tree = tree;
        node     = 0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            new_tree[node] = ~touch_way[WAY_W-1-lvl];
            node = touch_way[WAY_W-1-lvl] ? (2 * node + 2) : (2 * node + 1);
        end
    end

endmodule

// File: rtl/plru_set_controller.sv
// ----------------------------------------------------------------------------
// plru_set_controller
//
// Stateful tree pseudo-LRU manager for a whole set-associative cache. It
// holds one PLRU tree per set and serves one request per cycle. Each request
// is a victim query, a touch, an allocate (victim plus touch), or a per-set
// clear. A flush pulse starts a sweep that clears every set, one set per
// cycle. Requests are stalled while the sweep runs.
//
// Ports:
//   clk         in   1      rising-edge clock
//   rst         in   1      asynchronous active-high reset
//   req_valid   in   1      request present
//   req_ready   out  1      request can be accepted this cycle
//   req_op      in   2      00 TOUCH, 01 VICTIM, 10 ALLOC, 11 CLEAR_SET
//   req_set     in   SET_W  target set
//   req_way     in   WAY_W  way to touch (TOUCH only)
//   flush_req   in   1      pulse: clear every set's tree
//   flush_busy  out  1      sweep in progress
//   rsp_valid   out  1      response for the request accepted last cycle
//   rsp_way     out  WAY_W  victim (VICTIM/ALLOC), echo (TOUCH), 0 (CLEAR)
// ----------------------------------------------------------------------------
module plru_set_controller
    import plru_pkg::*;
#(
    parameter int ASSOC    = 8,
    parameter int NUM_SETS = 64,
    localparam int WAY_W   = $clog2(ASSOC),
    localparam int SET_W   = $clog2(NUM_SETS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [SET_W-1:0] req_set,
    input  logic [WAY_W-1:0] req_way,
    input  logic             flush_req,
    output logic             flush_busy,
    output logic             rsp_valid,
    output logic [WAY_W-1:0] rsp_way
);

    fsm_state_e       state_q;
    fsm_state_e       state_d;
    logic [SET_W-1:0] sweep_q;
    logic [SET_W-1:0] sweep_d;
    logic             sweep_clear;

    logic [ASSOC-2:0] trees [NUM_SETS];
    logic [ASSOC-2:0] cur_tree;
    logic [ASSOC-2:0] upd_tree;
    logic [WAY_W-1:0] victim;
    logic [WAY_W-1:0] touch_way;
    logic [WAY_W-1:0] rsp_way_d;
    logic             accept;
    op_e              op;

    assign op       = op_e'(req_op);
    assign accept   = req_valid && req_ready;
    assign cur_tree = trees[req_set];

    // An ALLOC touches the way it is about to return. This is the only place
    // where the victim is fed back into the update path.
    assign touch_way = (op == OP_ALLOC) ? victim : req_way;

    plru_tree_logic #(
        .ASSOC(ASSOC)
    ) u_tree_logic (
        .tree      (cur_tree),
        .touch_way (touch_way),
        .victim    (victim),
        .new_tree  (upd_tree)
    );

    // Control FSM, next-state half. A flush pulse seen in IDLE drops
    // req_ready in the same cycle, so the flush wins over a request that
    // arrives with it. In FLUSH one set is cleared per cycle. The machine
    // leaves FLUSH after the last set, so the sweep lasts exactly NUM_SETS
    // cycles. Further flush pulses during the sweep have no effect.
    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        req_ready   = 1'b0;
        flush_busy  = 1'b0;
        sweep_clear = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = !flush_req;
                if (flush_req) begin
                    state_d = S_FLUSH;
                    sweep_d = '0;
                end
            end
            S_FLUSH: begin
                flush_busy  = 1'b1;
                sweep_clear = 1'b1;
                sweep_d     = sweep_q + 1'b1;
                if (sweep_q == SET_W'(NUM_SETS - 1)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                sweep_d = '0;
            end
        endcase
    end

    // Control FSM, state register half. It also holds the sweep counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    // Tree storage. Sweep clears and accepted requests never occur in the
    // same cycle, because req_ready is low throughout FLUSH. A VICTIM query
    // leaves the tree alone. CLEAR_SET writes zeros, and TOUCH/ALLOC write
    // the updated tree back. A later request to the same set reads these
    // registers directly, so it always sees this update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SETS; i++) begin
                trees[i] <= '0;
            end
        end else if (sweep_clear) begin
            trees[sweep_q] <= '0;
        end else if (accept && (op != OP_VICTIM)) begin
            trees[req_set] <= (op == OP_CLEAR_SET) ? '0 : upd_tree;
        end
    end

    // Response payload, chosen by opcode from the tree state before the
    // write.
    always_comb begin
        rsp_way_d = '0;
        case (op)
            OP_TOUCH:     rsp_way_d = req_way;
            OP_VICTIM:    rsp_way_d = victim;
            OP_ALLOC:     rsp_way_d = victim;
            OP_CLEAR_SET: rsp_way_d = '0;
            default:      rsp_way_d = '0;
        endcase
    end

    // Registered response. rsp_valid is a one-cycle pulse after each
    // accept. rsp_way keeps its last value between responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_way   <= '0;
        end else begin
            rsp_valid <= accept;
            if (accept) begin
                rsp_way <= rsp_way_d;
            end
        end
    end

endmodule
